// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive stage; synchronises rx, qualifies the start bit at
// mid-bit and samples each data/stop bit once per OVERSAMPLE baud_tick pulses.
module uart_receiver #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s, rx_prev;
    logic [TW-1:0]          tick_cnt, tick_n;
    logic [BW-1:0]          bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n, data_n;
    logic                   done_n, err_n;

    assign rx_s    = sync[SYNC_STAGES-1];
    assign rx_busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync         <= '1;
            rx_prev      <= 1'b1;
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_done      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync         <= {sync[SYNC_STAGES-2:0], rx};
            rx_prev      <= rx_s;
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shift_reg    <= shift_n;
            rx_data      <= data_n;
            rx_done      <= done_n;
            rx_frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                // edge detect keeps a held-low line (break) from re-arming
                if (rx_prev && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == T_HALF) begin
                        state_n = rx_s ? IDLE : DATA;
                        tick_n  = '0;
                        bit_n   = '0;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == T_LAST) begin
                        shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
                        tick_n  = '0;
                        state_n = bit_cnt == B_LAST ? STOP : DATA;
                        bit_n   = bit_cnt == B_LAST ? '0 : bit_cnt + 1'b1;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == T_LAST) begin
                        state_n = IDLE;
                        tick_n  = '0;
                        done_n  = rx_s;
                        err_n   = !rx_s;
                        data_n  = rx_s ? shift_reg : rx_data;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
